// File: rtl/pipe_datapath_param.sv
// Three-stage EX/MEM/WB execution datapath: register file, ALU, MEM/WB forwarding,
// load-use stall, decode flush and registered NZCV flags.
module pipe_datapath_param #(
  parameter int WIDTH    = 32,
  parameter int NREG     = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     decValid,
  input  logic [$clog2(NREG)-1:0]  decRdAdrx0,
  input  logic [$clog2(NREG)-1:0]  decRdAdrx1,
  input  logic                     decUseRd0,
  input  logic                     decUseRd1,
  input  logic [$clog2(NREG)-1:0]  decWrAdrx,
  input  logic                     decWrEn,
  input  logic [2:0]               decAluCtl,
  input  logic                     decBSel,
  input  logic [WIDTH-1:0]         decImm,
  input  logic                     decLoad,
  input  logic                     decStore,
  input  logic                     decSetFlags,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         dmemRdData,
  output logic                     stall,
  output logic [WIDTH-1:0]         dmemAdrx,
  output logic [WIDTH-1:0]         dmemWrData,
  output logic                     dmemWrEn,
  output logic                     dmemRdEn,
  output logic                     flagN,
  output logic                     flagZ,
  output logic                     flagC,
  output logic                     flagV,
  output logic                     wbValid,
  output logic [$clog2(NREG)-1:0]  wbWrAdrx,
  output logic [WIDTH-1:0]         wbData
);
  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  logic [WIDTH-1:0] rf [NREG];

  logic             mem_valid, mem_wr_en, mem_load, mem_store;
  logic [AW-1:0]    mem_dest;
  logic [WIDTH-1:0] mem_result, mem_data;

  logic             wb_valid_q, wb_wr_en, wb_load;
  logic [AW-1:0]    wb_dest;
  logic [WIDTH-1:0] wb_result;

  logic             src0_zero, src1_zero, issue;
  logic [WIDTH-1:0] fwd_a, fwd_b, alu_b, b_eff, alu_res;
  logic [WIDTH:0]   sum;
  logic             is_sub, alu_c, alu_v;

  assign wbData = wb_load ? dmemRdData : wb_result;

  always_comb begin
    src0_zero = ZERO_REG && (decRdAdrx0 == '0);
    src1_zero = ZERO_REG && (decRdAdrx1 == '0);

    fwd_a = src0_zero ? '0 : rf[decRdAdrx0];
    if (mem_valid && mem_wr_en && !mem_load && mem_dest == decRdAdrx0 && !src0_zero)
      fwd_a = mem_result;
    else if (wb_valid_q && wb_wr_en && wb_dest == decRdAdrx0 && !src0_zero)
      fwd_a = wbData;

    fwd_b = src1_zero ? '0 : rf[decRdAdrx1];
    if (mem_valid && mem_wr_en && !mem_load && mem_dest == decRdAdrx1 && !src1_zero)
      fwd_b = mem_result;
    else if (wb_valid_q && wb_wr_en && wb_dest == decRdAdrx1 && !src1_zero)
      fwd_b = wbData;
  end

  // Only a load in MEM can stall: its data is not available until WB.
  always_comb begin
    stall = decValid && !flush && mem_valid && mem_load && mem_wr_en &&
            !(ZERO_REG && mem_dest == '0) &&
            ((decUseRd0 && mem_dest == decRdAdrx0) || (decUseRd1 && mem_dest == decRdAdrx1));
    issue = decValid && !flush && !stall;
  end

  always_comb begin
    alu_b   = decBSel ? decImm : fwd_b;
    is_sub  = (decAluCtl == 3'b001);
    b_eff   = is_sub ? ~alu_b : alu_b;
    sum     = {1'b0, fwd_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (decAluCtl)
      3'b000, 3'b001: begin
        alu_res = sum[M:0];
        alu_c   = sum[WIDTH];
        alu_v   = (fwd_a[M] == b_eff[M]) && (sum[M] != fwd_a[M]);
      end
      3'b010:  alu_res = fwd_a & alu_b;
      3'b011:  alu_res = fwd_a | alu_b;
      3'b100:  alu_res = fwd_a ^ alu_b;
      3'b101:  alu_res = fwd_a << alu_b[SW-1:0];
      3'b110:  alu_res = fwd_a >> alu_b[SW-1:0];
      default: alu_res[0] = $signed(fwd_a) < $signed(alu_b);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid  <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_load   <= 1'b0;
      mem_store  <= 1'b0;
      mem_dest   <= '0;
      mem_result <= '0;
      mem_data   <= '0;
      wb_valid_q <= 1'b0;
      wb_wr_en   <= 1'b0;
      wb_load    <= 1'b0;
      wb_dest    <= '0;
      wb_result  <= '0;
      {flagN, flagZ, flagC, flagV} <= '0;
    end else begin
      mem_valid  <= issue;
      mem_wr_en  <= decWrEn;
      mem_load   <= decLoad;
      mem_store  <= decStore;
      mem_dest   <= decWrAdrx;
      mem_result <= alu_res;
      mem_data   <= fwd_b;
      wb_valid_q <= mem_valid;
      wb_wr_en   <= mem_wr_en;
      wb_load    <= mem_load;
      wb_dest    <= mem_dest;
      wb_result  <= mem_result;
      if (issue && decSetFlags)
        {flagN, flagZ, flagC, flagV} <= {alu_res[M], alu_res == '0, alu_c, alu_v};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_valid_q && wb_wr_en && !(ZERO_REG && wb_dest == '0)) begin
      rf[wb_dest] <= wbData;
    end
  end

  assign dmemAdrx   = mem_result;
  assign dmemWrData = mem_data;
  assign dmemWrEn   = mem_valid && mem_store;
  assign dmemRdEn   = mem_valid && mem_load;
  assign wbValid    = wb_valid_q;
  assign wbWrAdrx   = wb_dest;
endmodule
